// File: rtl/i2c_led_flasher_if.sv
// I2C pad bundle for the LED flasher. The open-drain SDA pad is split into the
// level seen on the wire (sda_in) and a pull-low enable (sda_drive_low); the pad
// is 0 while sda_drive_low is 1 and Z otherwise, so the slave can never drive 1.
// SCL is an input only because the slave never stretches the clock.
interface i2c_led_flasher_if;
  logic scl;
  logic sda_in;
  logic sda_drive_low;

  modport slave  (input scl, input sda_in, output sda_drive_low);
  modport master (output scl, output sda_in, input sda_drive_low);
endinterface

// File: rtl/i2c_led_flasher.sv
// I2C slave with a three-entry register file that drives two blinking LEDs.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | bus ignored until a START is seen
// S_ADDR     | shifting in the 8-bit address byte
// S_ADDR_ACK | address matched; holding ACK low through the 9th SCL pulse
// S_WRITE    | shifting in a {type, payload} byte from the master
// S_WR_ACK   | holding ACK low through the 9th SCL pulse of a written byte
// S_READ     | shifting {00, register[pointer]} out MSB first
// S_RD_ACK   | SDA released; sampling the master's ACK/NACK
module i2c_led_flasher #(
  parameter logic [7:0] I2C_ADDR   = 8'h82,
  parameter int         BLINK_BITS = 22,
  parameter int         DATA_BITS  = 6
) (
  input  logic                CLK,
  input  logic                GSRn,
  i2c_led_flasher_if.slave    bus,
  output logic                LEDR,
  output logic                LEDG
);

  localparam int TYPE_BITS = 8 - DATA_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WR_ACK, S_READ, S_RD_ACK
  } state_t;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  state_t                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [6:0]             tx_q, tx_d;
  logic                   rw_q, rw_d;
  logic                   sda_oe_q, sda_oe_d;
  logic [DATA_BITS-1:0]   ptr_q, ptr_d;
  logic [DATA_BITS-1:0]   scratch_q, scratch_d;
  logic [DATA_BITS-1:0]   ctrl_q, ctrl_d;

  logic [7:0]             rx_byte, rd_byte;
  logic [TYPE_BITS-1:0]   rx_type;
  logic [DATA_BITS-1:0]   rx_payload, rd_data;

  logic [BLINK_BITS-1:0]  blink_q;
  logic                   phase_q, ledr_q, ledg_q;

  // Synchronise the bus lines; reset to the idle-high level so release of
  // reset cannot fabricate a START.
  always_ff @(posedge CLK or negedge GSRn) begin
    if (!GSRn) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], bus.scl};
      sda_sync_q <= {sda_sync_q[0], bus.sda_in};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  // The byte as it stands once the current SCL-rise bit is shifted in.
  assign rx_byte    = {shift_q[6:0], sda_s};
  assign rx_type    = rx_byte[7:DATA_BITS];
  assign rx_payload = rx_byte[DATA_BITS-1:0];

  // Register read mux; unmapped pointers read as zero.
  always_comb begin
    rd_data = '0;
    case (ptr_q)
      DATA_BITS'(0): rd_data = DATA_BITS'(6'h2A);
      DATA_BITS'(1): rd_data = scratch_q;
      DATA_BITS'(2): rd_data = ctrl_q;
      default:       rd_data = '0;
    endcase
  end

  assign rd_byte = {{TYPE_BITS{1'b0}}, rd_data};

  // FSM state and register file.
  always_ff @(posedge CLK or negedge GSRn) begin
    if (!GSRn) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      ptr_q     <= '0;
      scratch_q <= '0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      ptr_q     <= ptr_d;
      scratch_q <= scratch_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // Next-state logic; START/STOP override whatever the FSM is doing.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    ptr_d     = ptr_q;
    scratch_d = scratch_q;
    ctrl_d    = ctrl_q;

    if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ADDR: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shift_q[7:1] == I2C_ADDR[7:1]) begin
              sda_oe_d = 1'b1;
              rw_d     = shift_q[0];
              state_d  = S_ADDR_ACK;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              tx_d     = rd_byte[6:0];
              sda_oe_d = ~rd_byte[7];
              state_d  = S_READ;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            // Commit on the 8th bit so the LEDs follow before the ACK slot.
            if (bit_cnt_q == 4'd7) begin
              if (rx_type == TYPE_BITS'(0)) begin
                ptr_d = rx_payload;
              end else if (rx_type == TYPE_BITS'(1)) begin
                if (ptr_q == DATA_BITS'(1)) scratch_d = rx_payload;
                if (ptr_q == DATA_BITS'(2)) ctrl_d    = rx_payload;
              end
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            state_d  = S_WR_ACK;
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = S_WRITE;
          end
        end
        S_READ: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = S_RD_ACK;
            end else begin
              sda_oe_d = ~tx_q[6];
              tx_d     = {tx_q[5:0], 1'b0};
            end
          end
        end
        S_RD_ACK: begin
          // bit_cnt_q == 1 marks "master ACKed, resend after SCL falls".
          if (scl_rise) begin
            if (sda_s) state_d = S_IDLE;
            else       bit_cnt_d = 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d = '0;
            tx_d      = rd_byte[6:0];
            sda_oe_d  = ~rd_byte[7];
            state_d   = S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.sda_drive_low = sda_oe_q;

  // Blink timebase: phase flips each time the counter wraps, i.e. once
  // every 2^BLINK_BITS clocks; control writes never disturb it.
  always_ff @(posedge CLK or negedge GSRn) begin
    if (!GSRn) begin
      blink_q <= '0;
      phase_q <= 1'b0;
    end else begin
      blink_q <= blink_q + BLINK_BITS'(1);
      if (&blink_q) phase_q <= ~phase_q;
    end
  end

  // Registered LED drive: OFF wins, then MODE picks synchronous/alternating.
  always_ff @(posedge CLK or negedge GSRn) begin
    if (!GSRn) begin
      ledr_q <= 1'b0;
      ledg_q <= 1'b0;
    end else if (ctrl_q[1]) begin
      ledr_q <= 1'b0;
      ledg_q <= 1'b0;
    end else begin
      ledr_q <= phase_q;
      ledg_q <= ctrl_q[0] ? phase_q : ~phase_q;
    end
  end

  assign LEDR = ledr_q;
  assign LEDG = ledg_q;

endmodule

// File: tb/tb_i2c_led_flasher.sv
// Randomised I2C master driving the LED flasher, with a scoreboard of expected
// ACK bits and read bytes and a register-level model of the slave.
module tb_i2c_led_flasher;
  localparam int BB = 4;
  localparam int Q  = 6;
  localparam int K_ACK = 256;
  localparam int K_RD  = 512;

  logic CLK = 1'b0;
  logic GSRn = 1'b0;
  logic LEDR, LEDG;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  i2c_led_flasher_if bus();
  assign bus.scl    = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_drive_low;

  i2c_led_flasher #(.I2C_ADDR(8'h82), .BLINK_BITS(BB), .DATA_BITS(6)) dut (
    .CLK(CLK), .GSRn(GSRn), .bus(bus), .LEDR(LEDR), .LEDG(LEDG));

  always #25 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int obs_q[$];
  int m_ptr, m_scratch, m_ctrl;
  int low_cnt = 0;
  logic [7:0] wbuf[$];

  always @(posedge CLK) if (bus.sda_drive_low) low_cnt <= low_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic w(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Register-level model of the slave.
  function automatic int model_read();
    if (m_ptr == 0) return 'h2A;
    if (m_ptr == 1) return m_scratch;
    if (m_ptr == 2) return m_ctrl;
    return 0;
  endfunction

  task automatic model_write(input logic [7:0] b);
    if (b[7:6] == 2'b00) m_ptr = int'(b[5:0]);
    else if (b[7:6] == 2'b01) begin
      if (m_ptr == 1) m_scratch = int'(b[5:0]);
      else if (m_ptr == 2) m_ctrl = int'(b[5:0]);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_scratch = 0; m_ctrl = 0;
  endtask

  // Bus-level master primitives.
  task automatic i2c_start();
    sda_m = 1'b1; w(Q);
    scl_m = 1'b1; w(Q);
    sda_m = 1'b0; w(Q);
    scl_m = 1'b0; w(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; w(Q);
    scl_m = 1'b1; w(Q);
    sda_m = 1'b1; w(2*Q);
  endtask

  task automatic write_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; w(Q);
      scl_m = 1'b1; w(Q); w(Q);
      scl_m = 1'b0; w(Q);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, input int exp_ack);
    exp_q.push_back(K_ACK | exp_ack);
    write_bits(b, 8);
    sda_m = 1'b1; w(Q);
    scl_m = 1'b1; w(Q);
    obs_q.push_back(K_ACK | int'(bus.sda_in));
    w(Q);
    scl_m = 1'b0; w(Q);
  endtask

  task automatic read_byte(input logic nack);
    logic [7:0] b;
    b = '0;
    exp_q.push_back(K_RD | model_read());
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w(Q);
      scl_m = 1'b1; w(Q);
      b = {b[6:0], bus.sda_in};
      w(Q);
      scl_m = 1'b0;
    end
    obs_q.push_back(K_RD | int'(b));
    w(2);
    sda_m = nack; w(Q);
    scl_m = 1'b1; w(Q); w(Q);
    scl_m = 1'b0; w(Q);
    sda_m = 1'b1;
  endtask

  // Whole transactions, updating the model as the slave should.
  task automatic txn_write(input logic [7:0] abyte);
    logic hit;
    hit = (abyte[7:1] == 7'h41) && !abyte[0];
    i2c_start();
    write_byte(abyte, hit ? 0 : 1);
    foreach (wbuf[i]) begin
      write_byte(wbuf[i], hit ? 0 : 1);
      if (hit) model_write(wbuf[i]);
    end
    i2c_stop();
  endtask

  task automatic txn_read(input int n, input logic [5:0] p, input logic rep);
    i2c_start();
    write_byte(8'h82, 0);
    write_byte({2'b00, p}, 0);
    model_write({2'b00, p});
    if (!rep) i2c_stop();
    i2c_start();
    write_byte(8'h83, 0);
    for (int k = 0; k < n; k++) read_byte(k == n - 1);
    i2c_stop();
  endtask

  task automatic check_leds();
    int bad;
    logic seen0, seen1;
    int exp_x;
    bad = 0; seen0 = 0; seen1 = 0;
    exp_x = (m_ctrl & 2) ? 0 : ((m_ctrl & 1) ? 0 : 1);
    for (int i = 0; i < 2 * (1 << BB) + 4; i++) begin
      @(negedge CLK);
      if (int'(LEDR ^ LEDG) != exp_x) bad++;
      if ((m_ctrl & 2) && (LEDR || LEDG)) bad++;
      if (LEDR) seen1 = 1; else seen0 = 1;
    end
    check("led_relation", bad, 0);
    if ((m_ctrl & 2) == 0) check("led_toggling", int'(seen0 && seen1), 1);
  endtask

  task automatic check_period();
    logic prev;
    int n;
    n = 0;
    @(negedge CLK); prev = LEDR;
    while (LEDR == prev && n < 100) begin @(negedge CLK); n++; end
    prev = LEDR; n = 0;
    while (LEDR == prev && n < 100) begin @(negedge CLK); n++; end
    check("led_period", n, 1 << BB);
  endtask

  // Scoreboard monitor: compare each DUT response against the next expectation.
  initial begin
    int o, e;
    forever begin
      @(negedge CLK);
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        if (exp_q.size() == 0) begin
          check("unexpected_response", o, -1);
        end else begin
          e = exp_q.pop_front();
          check((e & K_RD) ? "read_data" : "ack_bit", o, e);
        end
      end
    end
  end

  initial begin
    #4ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lb, r, nb;
    logic [7:0] b;
    model_reset();

    // Reset state
    w(2);
    check("reset_leds", int'({LEDR, LEDG}), 0);
    check("reset_sda", int'(bus.sda_drive_low), 0);
    w(1);
    GSRn = 1'b1;
    w(3);
    check_leds();

    // Write reg2 = 0x01 (synchronous mode), confirm by readback
    wbuf = '{8'h02, 8'h41};
    txn_write(8'h82);
    check_leds();
    txn_read(1, 6'h02, 1'b0);

    // Wrong address: NACK, SDA never pulled, reg2 unchanged
    lb = low_cnt;
    wbuf = '{8'h02};
    txn_write(8'h84);
    check("no_drive_on_mismatch", low_cnt - lb, 0);
    txn_read(1, 6'h02, 1'b1);

    // Scratch write then repeated-START read
    i2c_start();
    write_byte(8'h82, 0);
    write_byte(8'h01, 0); model_write(8'h01);
    write_byte(8'h55, 0); model_write(8'h55);
    i2c_start();
    write_byte(8'h83, 0);
    read_byte(1'b1);
    i2c_stop();

    // Blink period, then OFF
    check_period();
    wbuf = '{8'h02, 8'h42};
    txn_write(8'h82);
    check_leds();

    // Reset in the middle of a write byte
    wbuf = '{8'h02, 8'h41};
    txn_write(8'h82);
    i2c_start();
    write_byte(8'h82, 0);
    write_bits(8'h41, 4);
    GSRn = 1'b0;
    w(1);
    check("midreset_sda", int'(bus.sda_drive_low), 0);
    check("midreset_leds", int'({LEDR, LEDG}), 0);
    w(2);
    scl_m = 1'b1; w(2);
    sda_m = 1'b1;
    model_reset();
    GSRn = 1'b1;
    w(Q);
    txn_read(1, 6'h02, 1'b0);
    check_leds();

    // Randomised traffic
    for (int it = 0; it < 24; it++) begin
      r = $urandom_range(0, 3);
      if (r <= 1) begin
        wbuf.delete();
        nb = $urandom_range(1, 3);
        for (int j = 0; j < nb; j++) begin
          b = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 1) == 0) b = {2'b00, 6'($urandom_range(0, 3))};
          wbuf.push_back(b);
        end
        if ($urandom_range(0, 5) == 0) begin
          b = {7'($urandom_range(0, 127)), 1'b0};
          if (b[7:1] == 7'h41) b = 8'h84;
          txn_write(b);
        end else begin
          txn_write(8'h82);
        end
      end else if (r == 2) begin
        txn_read($urandom_range(1, 3), 6'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
      end else begin
        check_leds();
      end
    end
    check_leds();

    w(4);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
